// File: rtl/grid_scheduler.sv
// grid_scheduler: frame-level controller for the shared single-port 40x30 grid.
// A free-running tick counter paces the game. Each tick runs the player updater,
// enemy updater and renderer in that fixed order through start/done handshakes,
// routing the granted client's address/write signals onto the grid bus. A
// per-client watchdog abandons a client that never reports done.
module grid_scheduler #(
  parameter int TICK_CYCLES = 2000000,
  parameter int TIMEOUT     = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] client_en,
  input  logic       err_clear,
  output logic       c0_start,
  output logic       c1_start,
  output logic       c2_start,
  input  logic       c0_done,
  input  logic       c1_done,
  input  logic       c2_done,
  input  logic [5:0] c0_grid_x,
  input  logic [5:0] c1_grid_x,
  input  logic [5:0] c2_grid_x,
  input  logic [4:0] c0_grid_y,
  input  logic [4:0] c1_grid_y,
  input  logic [4:0] c2_grid_y,
  input  logic       c0_grid_write,
  input  logic       c1_grid_write,
  input  logic       c2_grid_write,
  input  logic [2:0] c0_grid_in,
  input  logic [2:0] c1_grid_in,
  input  logic [2:0] c2_grid_in,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  output logic       grid_write,
  output logic [2:0] grid_in,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun_err,
  output logic       timeout_err,
  output logic [1:0] active
);

  // Counter widths; the watchdog keeps at least one bit so TIMEOUT=1 still builds.
  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);

  // Index value meaning "all three clients have been visited".
  localparam logic [1:0] IDX_END = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_FRAME_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [WD_W-1:0]   w_wd_nxt;
  logic              r_pending;
  logic              r_overrun_err;
  logic              r_timeout_err;

  logic              w_tick;
  logic              w_sel_en;
  logic              w_sel_done;
  logic              w_timeout_set;
  logic              w_overrun_set;
  logic              w_granted;

  assign w_tick        = (r_tick_cnt == '0);
  assign w_overrun_set = w_tick && (r_state != S_IDLE);
  assign w_granted     = (r_state == S_START) || (r_state == S_WAIT);

  // Free-running tick counter: counts down and reloads, period TICK_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: registered state is always written with non-blocking assignments so
    // every flop samples its inputs from the same pre-edge snapshot.
    if (reset) begin
      r_tick_cnt <= TICK_RELOAD;
    end else if (w_tick) begin
      r_tick_cnt <= TICK_RELOAD;
    end else begin
      r_tick_cnt <= r_tick_cnt - 1'b1;
    end
  end

  // Select the enable and done of the client currently pointed at by idx.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch; a path
    // that leaves a variable unassigned would otherwise infer a latch.
    w_sel_en   = 1'b0;
    w_sel_done = 1'b0;
    case (r_idx)
      2'd0: begin
        w_sel_en   = client_en[0];
        w_sel_done = c0_done;
      end
      2'd1: begin
        w_sel_en   = client_en[1];
        w_sel_done = c1_done;
      end
      2'd2: begin
        w_sel_en   = client_en[2];
        w_sel_done = c2_done;
      end
      default: begin
        w_sel_en   = 1'b0;
        w_sel_done = 1'b0;
      end
    endcase
  end

  // FSM state, client index and watchdog registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_wd_cnt <= w_wd_nxt;
    end
  end

  // Next-state logic: walk the clients in order, one handshake each.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wd_nxt      = r_wd_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick || r_pending) begin
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == IDX_END) begin
          w_state_nxt = S_FRAME_DONE;
        end else if (w_sel_en) begin
          w_state_nxt = S_START;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end
      S_START: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (w_sel_done) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = S_SCAN;
        end else if (r_wd_cnt == WD_LAST) begin
          w_timeout_set = 1'b1;
          w_idx_nxt     = r_idx + 2'd1;
          w_state_nxt   = S_SCAN;
        end else begin
          w_wd_nxt = r_wd_cnt + 1'b1;
        end
      end
      S_FRAME_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Remember at most one tick that arrived while a frame was still running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      // In IDLE a pending tick is consumed immediately by leaving IDLE.
      r_pending <= 1'b0;
    end else if (w_tick) begin
      r_pending <= 1'b1;
    end
  end

  // Sticky error flags; a new error event takes priority over err_clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun_err <= 1'b1;
      end else if (err_clear) begin
        r_overrun_err <= 1'b0;
      end
      if (w_timeout_set) begin
        r_timeout_err <= 1'b1;
      end else if (err_clear) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  // Grid bus mux: only the granted client reaches the grid, otherwise all zero.
  always_comb begin
    grid_x     = 6'd0;
    grid_y     = 5'd0;
    grid_write = 1'b0;
    grid_in    = 3'd0;
    active     = IDX_END;
    if (w_granted) begin
      case (r_idx)
        2'd0: begin
          grid_x     = c0_grid_x;
          grid_y     = c0_grid_y;
          grid_write = c0_grid_write;
          grid_in    = c0_grid_in;
          active     = 2'd0;
        end
        2'd1: begin
          grid_x     = c1_grid_x;
          grid_y     = c1_grid_y;
          grid_write = c1_grid_write;
          grid_in    = c1_grid_in;
          active     = 2'd1;
        end
        2'd2: begin
          grid_x     = c2_grid_x;
          grid_y     = c2_grid_y;
          grid_write = c2_grid_write;
          grid_in    = c2_grid_in;
          active     = 2'd2;
        end
        default: begin
          active = IDX_END;
        end
      endcase
    end
  end

  // Status and handshake outputs decoded from the registered state.
  always_comb begin
    busy        = (r_state != S_IDLE);
    frame_done  = (r_state == S_FRAME_DONE);
    c0_start    = (r_state == S_START) && (r_idx == 2'd0);
    c1_start    = (r_state == S_START) && (r_idx == 2'd1);
    c2_start    = (r_state == S_START) && (r_idx == 2'd2);
    overrun_err = r_overrun_err;
    timeout_err = r_timeout_err;
  end

endmodule

// File: tb/tb_grid_scheduler.sv
// Directed bench for grid_scheduler with TICK_CYCLES=20 and TIMEOUT=8.
// A behavioural client model answers each start with done after a programmable
// delay (0 = never answers). Cycle numbers of starts, busy rises and frame_done
// pulses are logged at the falling edge; the main sequence checks them against
// hand-derived schedules. For a frame whose first SCAN cycle is X with all three
// clients enabled and delay D: starts at X+1, X+3+D, X+5+2D; frame_done at X+7+3D.
module tb_grid_scheduler;

  localparam int TICK = 20;
  localparam int TOUT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] client_en;
  logic       err_clear;
  logic       c0_start, c1_start, c2_start;
  logic       c0_done, c1_done, c2_done;
  logic [5:0] c0_grid_x, c1_grid_x, c2_grid_x;
  logic [4:0] c0_grid_y, c1_grid_y, c2_grid_y;
  logic       c0_grid_write, c1_grid_write, c2_grid_write;
  logic [2:0] c0_grid_in, c1_grid_in, c2_grid_in;
  logic [5:0] grid_x;
  logic [4:0] grid_y;
  logic       grid_write;
  logic [2:0] grid_in;
  logic       busy, frame_done, overrun_err, timeout_err;
  logic [1:0] active;

  grid_scheduler #(.TICK_CYCLES(TICK), .TIMEOUT(TOUT)) dut (
    .clock(clock), .reset(reset), .client_en(client_en), .err_clear(err_clear),
    .c0_start(c0_start), .c1_start(c1_start), .c2_start(c2_start),
    .c0_done(c0_done), .c1_done(c1_done), .c2_done(c2_done),
    .c0_grid_x(c0_grid_x), .c1_grid_x(c1_grid_x), .c2_grid_x(c2_grid_x),
    .c0_grid_y(c0_grid_y), .c1_grid_y(c1_grid_y), .c2_grid_y(c2_grid_y),
    .c0_grid_write(c0_grid_write), .c1_grid_write(c1_grid_write),
    .c2_grid_write(c2_grid_write),
    .c0_grid_in(c0_grid_in), .c1_grid_in(c1_grid_in), .c2_grid_in(c2_grid_in),
    .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write), .grid_in(grid_in),
    .busy(busy), .frame_done(frame_done), .overrun_err(overrun_err),
    .timeout_err(timeout_err), .active(active)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Client model and event log
  int         d_cfg [3];
  int         rem [3];
  bit         pend [3];
  logic [2:0] model_done = 3'b000;
  logic [2:0] extra_done = 3'b000;
  int         start_cyc [3];
  int         start_cnt [3];
  int         fd_cyc = -1;
  int         fd_cnt = 0;
  int         rise_cyc = -1;
  int         rise_cnt = 0;
  logic       busy_q = 1'b0;
  logic [2:0] w_starts;

  assign w_starts = {c2_start, c1_start, c0_start};
  assign c0_done  = model_done[0] | extra_done[0];
  assign c1_done  = model_done[1] | extra_done[1];
  assign c2_done  = model_done[2] | extra_done[2];

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      model_done[k] = 1'b0;
      if (reset) begin
        pend[k] = 1'b0;
      end else begin
        if (pend[k]) begin
          rem[k] = rem[k] - 1;
          if (rem[k] == 0) begin
            model_done[k] = 1'b1;
            pend[k]       = 1'b0;
          end
        end
        if (w_starts[k]) begin
          start_cyc[k] = cyc;
          start_cnt[k] = start_cnt[k] + 1;
          if (d_cfg[k] > 0) begin
            pend[k] = 1'b1;
            rem[k]  = d_cfg[k];
          end
        end
      end
    end
    if (frame_done) begin
      fd_cyc = cyc;
      fd_cnt = fd_cnt + 1;
    end
    if (busy && !busy_q) begin
      rise_cyc = cyc;
      rise_cnt = rise_cnt + 1;
    end
    busy_q = busy;
  end

  // Checking helpers
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_rise(input string tag, output int x);
    int r0;
    int n;
    r0 = rise_cnt;
    n  = 0;
    while (rise_cnt == r0 && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(rise_cnt != r0), 32'd1);
    x = rise_cyc;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int r0, x1, x2, x4, x5, x6, x7, r6, f_before, s_before;

  initial begin
    reset         = 1'b1;
    client_en     = 3'b111;
    err_clear     = 1'b0;
    c0_grid_x = 6'd33; c0_grid_y = 5'd20; c0_grid_write = 1'b1; c0_grid_in = 3'd6;
    c1_grid_x = 6'd12; c1_grid_y = 5'd7;  c1_grid_write = 1'b1; c1_grid_in = 3'd4;
    c2_grid_x = 6'd39; c2_grid_y = 5'd29; c2_grid_write = 1'b0; c2_grid_in = 3'd2;
    for (int k = 0; k < 3; k++) begin
      d_cfg[k] = 3; rem[k] = 0; pend[k] = 1'b0; start_cyc[k] = -1; start_cnt[k] = 0;
    end
    repeat (3) step();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active", 32'(active), 32'd3);
    check("rst_grid_write", 32'(grid_write), 32'd0);
    check("rst_grid_x", 32'(grid_x), 32'd0);
    check("rst_starts", 32'(w_starts), 32'd0);
    check("rst_errs", 32'({overrun_err, timeout_err, frame_done}), 32'd0);

    reset = 1'b0;
    r0    = cyc;

    // Test 1: all clients, D=3
    wait_rise("t1_rise", x1);
    check("t1_first_frame_latency", 32'(x1 - r0), 32'(TICK));
    check("t1_scan_active", 32'(active), 32'd3);
    wait_until(x1 + 1);
    check("t1_c0_start", 32'(c0_start), 32'd1);
    check("t1_c0_active", 32'(active), 32'd0);
    check("t1_c0_grid_x", 32'(grid_x), 32'd33);
    wait_until(x1 + 11);
    check("t1_c2_start", 32'(c2_start), 32'd1);
    check("t1_c2_grid_write_blocked", 32'(grid_write), 32'd0);
    check("t1_c2_grid_x", 32'(grid_x), 32'd39);
    wait_until(x1 + 12);
    check("t1_c2_start_one_cycle", 32'(c2_start), 32'd0);
    wait_until(x1 + 17);
    check("t1_s0", 32'(start_cyc[0] - x1), 32'd1);
    check("t1_s1", 32'(start_cyc[1] - x1), 32'd6);
    check("t1_s2", 32'(start_cyc[2] - x1), 32'd11);
    check("t1_frame_done", 32'(fd_cyc - x1), 32'd16);
    check("t1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_errs", 32'({overrun_err, timeout_err}), 32'd0);

    // Test 2 and grid mux: only client 1, D=4
    client_en = 3'b010;
    d_cfg[1]  = 4;
    wait_rise("t2_rise", x2);
    check("t2_tick_period", 32'(x2 - x1), 32'(TICK));
    wait_until(x2 + 1);
    check("t2_skip_active", 32'(active), 32'd3);
    wait_until(x2 + 2);
    check("t2_c1_start", 32'(c1_start), 32'd1);
    check("t2_c1_active", 32'(active), 32'd1);
    wait_until(x2 + 3);
    check("t5_grid_x", 32'(grid_x), 32'd12);
    check("t5_grid_y", 32'(grid_y), 32'd7);
    check("t5_grid_write", 32'(grid_write), 32'd1);
    check("t5_grid_in", 32'(grid_in), 32'd4);
    check("t5_wait_active", 32'(active), 32'd1);
    wait_until(x2 + 7);
    check("t2_after_c1_active", 32'(active), 32'd3);
    wait_until(x2 + 10);
    check("t2_frame_done", 32'(fd_cyc - x2), 32'd9);
    check("t2_c0_not_started", 32'(start_cnt[0]), 32'd1);
    check("t2_c2_not_started", 32'(start_cnt[2]), 32'd1);
    check("t2_c1_started", 32'(start_cnt[1]), 32'd2);
    check("t5_idle_grid_write", 32'(grid_write), 32'd0);
    check("t5_idle_grid_x", 32'(grid_x), 32'd0);

    // Test 4: long frames (D=8, done on the last watchdog cycle) cause overrun
    client_en = 3'b111;
    for (int k = 0; k < 3; k++) d_cfg[k] = 8;
    wait_rise("t4_rise", x4);
    check("t4_tick_period", 32'(x4 - x2), 32'(TICK));
    wait_until(x4 + 19);
    check("t4_overrun_before_tick", 32'(overrun_err), 32'd0);
    wait_until(x4 + 20);
    check("t4_overrun_set", 32'(overrun_err), 32'd1);
    wait_until(x4 + 32);
    check("t4_frame1_done", 32'(fd_cyc - x4), 32'd31);
    check("t4_done_beats_timeout", 32'(timeout_err), 32'd0);
    check("t4_idle_between", 32'(busy), 32'd0);
    wait_until(x4 + 33);
    check("t4_pending_frame_start", 32'(rise_cyc - x4), 32'd33);
    wait_until(x4 + 55);
    client_en = 3'b000;
    s_before  = start_cnt[0] + start_cnt[1] + start_cnt[2];
    wait_until(x4 + 65);
    check("t4_frame2_done", 32'(fd_cyc - x4), 32'd64);
    f_before = fd_cnt;
    wait_until(x4 + 66);
    check("t4_frame3_start", 32'(rise_cyc - x4), 32'd66);
    wait_until(x4 + 78);
    check("t4_single_extra_frame", 32'(fd_cnt - f_before), 32'd1);
    check("t4_frame3_done", 32'(fd_cyc - x4), 32'd70);
    check("t4_idle_after", 32'(busy), 32'd0);
    check("t4_no_starts_disabled",
          32'(start_cnt[0] + start_cnt[1] + start_cnt[2] - s_before), 32'd0);

    // Clear errors
    wait_until(x4 + 86);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t4_err_clear", 32'(overrun_err), 32'd0);

    // Test 3: client 1 hangs; stray done from client 0 is ignored
    client_en = 3'b111;
    d_cfg[0] = 1; d_cfg[1] = 0; d_cfg[2] = 1;
    wait_rise("t3_rise", x5);
    check("t3_frame_start", 32'(x5 - x4), 32'd100);
    wait_until(x5 + 4);
    check("t3_c1_start", 32'(c1_start), 32'd1);
    wait_until(x5 + 7);
    extra_done[0] = 1'b1;
    step();
    extra_done[0] = 1'b0;
    check("t3_foreign_done_ignored", 32'(active), 32'd1);
    wait_until(x5 + 12);
    check("t3_last_wait_active", 32'(active), 32'd1);
    check("t3_timeout_not_yet", 32'(timeout_err), 32'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t3_timeout_set_beats_clear", 32'(timeout_err), 32'd1);
    check("t3_abandoned_active", 32'(active), 32'd3);
    step();
    check("t3_c2_start", 32'(c2_start), 32'd1);
    wait_until(x5 + 18);
    check("t3_frame_done", 32'(fd_cyc - x5), 32'd17);
    check("t3_timeout_sticky", 32'(timeout_err), 32'd1);
    check("t3_no_overrun", 32'(overrun_err), 32'd0);

    // Test 6: reset during client 2 WAIT
    for (int k = 0; k < 3; k++) d_cfg[k] = 4;
    wait_rise("t6_rise", x6);
    check("t6_frame_start", 32'(x6 - x5), 32'(TICK));
    wait_until(x6 + 15);
    check("t6_c2_wait", 32'(active), 32'd2);
    f_before = fd_cnt;
    s_before = start_cnt[0] + start_cnt[1] + start_cnt[2];
    reset = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_active", 32'(active), 32'd3);
    check("t6_async_grid_x", 32'(grid_x), 32'd0);
    check("t6_async_timeout_err", 32'(timeout_err), 32'd0);
    repeat (3) step();
    reset = 1'b0;
    r6    = cyc;
    wait_rise("t6_rise_after_reset", x7);
    check("t6_restart_latency", 32'(x7 - r6), 32'(TICK));
    check("t6_no_frame_done", 32'(fd_cnt - f_before), 32'd0);
    check("t6_no_starts", 32'(start_cnt[0] + start_cnt[1] + start_cnt[2] - s_before), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
